rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A (ALU writeback) has a write pending.
- a_addr  input  5  requester A destination register.
- a_data  input  32  requester A write data.
- a_ready  output  1  A's request accepted this cycle.
- b_valid  input  1  requester B (load unit) has a write pending.
- b_addr  input  5  requester B destination register.
- b_data  input  32  requester B write data.
- b_ready  output  1  B's request accepted this cycle.
- claim_valid  input  1  issue stage reserves a destination register.
- claim_addr  input  5  register being reserved.
- rs_q  input  5  hazard query address 1.
- rt_q  input  5  hazard query address 2.
- rs_busy  output  1  rs_q has an outstanding write.
- rt_busy  output  1  rt_q has an outstanding write.
- rd_addr  output  5  register-file write address.
- rd_data  output  32  register-file write data.
- reg_write  output  1  register-file write enable.

Function
REQ-002 A transfer on a port SHALL occur when valid and ready are both 1 in the same cycle; at most one transfer SHALL occur per cycle.
REQ-003 a_ready and b_ready SHALL be combinational from valids and priority pointer; never both 1; a requester SHALL be granted whenever it alone is valid.
REQ-004 When both are valid, the grant SHALL go to the requester named by the round-robin pointer; after any grant the pointer SHALL point to the other requester.
REQ-005 Ready SHALL NOT depend on the requester's own addr/data; a valid requester SHALL hold addr/data stable until its ready.
REQ-006 A transfer in cycle N SHALL drive reg_write=1, rd_addr, rd_data from posedge N+1 for exactly one cycle (latency 1), so they are stable at the register file's negedge write.
REQ-007 reg_write SHALL be 0 in any cycle not following a transfer; rd_addr/rd_data SHALL hold their last values.
REQ-008 A transfer with addr 0 SHALL be accepted (ready=1) but SHALL produce reg_write=0.
REQ-009 Scoreboard: busy[31:0]; claim_valid sets busy[claim_addr] at the next posedge; a reg_write cycle clears busy[rd_addr] at the next posedge.
REQ-010 Simultaneous claim and clear of the same register SHALL leave busy=1 (claim wins); different registers SHALL both take effect.
REQ-011 Claims of register 0 SHALL be ignored; busy[0] SHALL always read 0.
REQ-012 rs_busy/rt_busy SHALL be combinational reads of busy[rs_q]/busy[rt_q] (current-cycle state, no write-through).

Reset
REQ-013 While rst=1 at posedge: reg_write=0, rd_addr=0, rd_data=0, busy=all 0, pointer=A.
REQ-014 While rst=1, a_ready=b_ready=0 and no transfer SHALL occur; a pending writeback register SHALL be discarded.
REQ-015 First grant after reset release SHALL go to A if both are valid.

Structure
REQ-016 Shared package rf_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, REG_COUNT=32 and the requester-id enum {REQ_A, REQ_B}.
REQ-017 The scoreboard (REQ-009..012) SHALL be a separate sub-module rf_scoreboard; arbitration and output register stay in the top.

Verification
REQ-018 A only, a_addr=5 a_data=0x1234 for 1 cycle -> a_ready=1; next cycle reg_write=1 rd_addr=5 rd_data=0x1234; then reg_write=0.
REQ-019 A and B valid 4 cycles after reset (A=3/0xA, B=4/0xB) -> grants A,B,A,B; writes 3,4,3,4 on consecutive cycles.
REQ-020 claim_addr=7, then rs_q=7 -> rs_busy=1 next cycle; B writes reg 7 -> rs_busy=0 the cycle after reg_write.
REQ-021 claim 9 in the same cycle reg_write clears 9 -> busy[9] stays 1; claim 0 -> rs_q=0 gives rs_busy=0.
REQ-022 A writes addr 0 data 0xFFFF -> a_ready=1, reg_write stays 0.
REQ-023 rst asserted the cycle after a transfer -> reg_write=0, all busy cleared, next contested grant goes to A.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths and requester identifiers for the register-file
//               write arbiter and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [0:0] {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy bits; set by issue-stage claims, cleared by
//               register-file writes, read combinationally for hazard queries.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  claim_valid,
    input  logic [REG_ADDR_W-1:0] claim_addr,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs_q,
    input  logic [REG_ADDR_W-1:0] rt_q,
    output logic                  rs_busy,
    output logic                  rt_busy
);

    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_busy_next;

    // Claim is applied after the clear so a same-register collision stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (clr_valid) begin
            w_busy_next[clr_addr] = 1'b0;
        end
        if (claim_valid) begin
            w_busy_next[claim_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign rs_busy = r_busy[rs_q];
    assign rt_busy = r_busy[rt_q];

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter merging ALU and load-unit writebacks into
//               a single registered register-file write port, plus scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  claim_valid,
    input  logic [REG_ADDR_W-1:0] claim_addr,
    input  logic [REG_ADDR_W-1:0] rs_q,
    input  logic [REG_ADDR_W-1:0] rt_q,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  reg_write
);

    req_id_e               r_ptr;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0]     r_rd_data;

    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0]     w_sel_data;

    // Grants depend only on valids, the pointer and reset, never on addr/data.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                a_ready = (r_ptr == REQ_A);
                b_ready = (r_ptr == REQ_B);
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign w_xfer     = a_ready | b_ready;
    assign w_sel_addr = b_ready ? b_addr : a_addr;
    assign w_sel_data = b_ready ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= REQ_A;
            r_reg_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            // Register 0 writes are accepted but never reach the register file.
            r_reg_write <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_rd_addr <= w_sel_addr;
                r_rd_data <= w_sel_data;
                r_ptr     <= a_ready ? REQ_B : REQ_A;
            end
        end
    end

    assign reg_write = r_reg_write;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .clr_valid   (r_reg_write),
        .clr_addr    (r_rd_addr),
        .rs_q        (rs_q),
        .rt_q        (rt_q),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed-vector bench with a cycle-level reference model and
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, claim_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0, claim_addr = '0, rs_q = '0, rt_q = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rs_busy, rt_busy, reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_busy [32];
    int          m_ptr = 0;
    bit          m_rw = 1'b0;
    logic [4:0]  m_rd_addr = '0;
    logic [31:0] m_rd_data = '0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .rs_q(rs_q), .rt_q(rt_q), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -1 = nobody, 0 = A, 1 = B
    function automatic int model_grant();
        if (rst) return -1;
        if (a_valid && b_valid) return m_ptr;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    // Model update at each posedge, then compare just before the next one.
    initial begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_ptr = 0; m_rw = 1'b0; m_rd_addr = '0; m_rd_data = '0;
            end else begin
                int g;
                g = model_grant();
                if (m_rw) m_busy[m_rd_addr] = 1'b0;
                if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
                m_rw = 1'b0;
                if (g >= 0) begin
                    m_rd_addr = (g == 0) ? a_addr : b_addr;
                    m_rd_data = (g == 0) ? a_data : b_data;
                    m_rw      = (m_rd_addr != 0);
                    m_ptr     = 1 - g;
                end
            end
            @(negedge clk);
            #4;
            begin
                int g;
                g = model_grant();
                chk("m_a_ready",   {31'b0, a_ready},   {31'b0, g == 0});
                chk("m_b_ready",   {31'b0, b_ready},   {31'b0, g == 1});
                chk("m_reg_write", {31'b0, reg_write}, {31'b0, m_rw});
                chk("m_rd_addr",   {27'b0, rd_addr},   {27'b0, m_rd_addr});
                chk("m_rd_data",   rd_data,            m_rd_data);
                chk("m_rs_busy",   {31'b0, rs_busy},   {31'b0, m_busy[rs_q]});
                chk("m_rt_busy",   {31'b0, rt_busy},   {31'b0, m_busy[rt_q]});
            end
        end
    end

    task automatic drv(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                       input bit cv, input logic [4:0] ca, input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        claim_valid = cv; claim_addr = ca; rs_q = rs; rt_q = rt;
        #4;
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, rs, rt);
    endtask

    initial begin
        // Reset state, with requests pending
        drv(1, 1, 5, 32'h1, 1, 6, 32'h2, 1, 3, 3, 0);
        drv(1, 1, 5, 32'h1, 1, 6, 32'h2, 1, 3, 3, 0);
        chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
        chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
        chk("rst_rd_addr", {27'b0, rd_addr}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rs_busy", {31'b0, rs_busy}, 32'd0);

        // Single A write
        drv(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        chk("a_only_ready", {31'b0, a_ready}, 32'd1);
        idle(0, 0);
        chk("a_only_we", {31'b0, reg_write}, 32'd1);
        chk("a_only_addr", {27'b0, rd_addr}, 32'd5);
        chk("a_only_data", rd_data, 32'h1234);
        idle(0, 0);
        chk("a_only_we_off", {31'b0, reg_write}, 32'd0);
        chk("a_only_hold", {27'b0, rd_addr}, 32'd5);

        // Claim 7, then B writes 7; claim 8 lands in the same cycle 7 is cleared
        drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        idle(7, 0);
        chk("claim7_busy", {31'b0, rs_busy}, 32'd1);
        drv(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
        chk("b7_ready", {31'b0, b_ready}, 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 8, 7, 0);
        chk("b7_we", {31'b0, reg_write}, 32'd1);
        chk("b7_addr", {27'b0, rd_addr}, 32'd7);
        chk("b7_busy_still", {31'b0, rs_busy}, 32'd1);
        idle(7, 8);
        chk("b7_cleared", {31'b0, rs_busy}, 32'd0);
        chk("claim8_busy", {31'b0, rt_busy}, 32'd1);

        // Claim 9 collides with the clear of 9; claim 0 is ignored
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        drv(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        chk("b9_we", {31'b0, reg_write}, 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0);
        chk("claim_wins", {31'b0, rs_busy}, 32'd1);
        idle(0, 9);
        chk("claim0_ignored", {31'b0, rs_busy}, 32'd0);
        chk("r9_still_busy", {31'b0, rt_busy}, 32'd1);

        // Write to register 0
        drv(0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        chk("a0_ready", {31'b0, a_ready}, 32'd1);
        idle(0, 0);
        chk("a0_no_we", {31'b0, reg_write}, 32'd0);

        // Reset right after a transfer; pointer left on B beforehand
        drv(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
        drv(0, 1, 6, 32'h66, 0, 0, 0, 0, 0, 6, 0);
        chk("a6_ready", {31'b0, a_ready}, 32'd1);
        drv(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 6, 0);
        chk("rst_blk_a", {31'b0, a_ready}, 32'd0);
        chk("rst_blk_b", {31'b0, b_ready}, 32'd0);
        chk("pre_rst_we", {31'b0, reg_write}, 32'd1);
        chk("pre_rst_busy6", {31'b0, rs_busy}, 32'd1);

        // Contested round-robin after reset release: A,B,A,B
        for (int k = 0; k < 4; k++) begin
            drv(0, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 6, 0);
            chk("rr_a_ready", {31'b0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", {31'b0, b_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 0) begin
                chk("post_rst_we", {31'b0, reg_write}, 32'd0);
                chk("post_rst_addr", {27'b0, rd_addr}, 32'd0);
                chk("post_rst_busy6", {31'b0, rs_busy}, 32'd0);
            end else begin
                chk("rr_we", {31'b0, reg_write}, 32'd1);
                chk("rr_addr", {27'b0, rd_addr}, (k % 2 == 1) ? 32'd3 : 32'd4);
                chk("rr_data", rd_data, (k % 2 == 1) ? 32'hA : 32'hB);
            end
        end
        idle(0, 0);
        chk("rr_last_addr", {27'b0, rd_addr}, 32'd4);
        chk("rr_last_we", {31'b0, reg_write}, 32'd1);
        idle(0, 0);
        chk("rr_done_we", {31'b0, reg_write}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
